// File: rtl/cdb_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// cdb_arbiter_pkg
// Shared types and constants for the common data bus (CDB) arbitration slice.
//   NUM_FU / TAG_W / ROB_PTR_W / DATA_W : default bus geometry
//   FU_ALU / FU_MDU / FU_LSU / FU_BR    : requester index of each unit
//   cdb_pkt_t                           : one broadcast result {tag, wdata, inst_id}
//   nextIdx()                           : modular successor used by the
//                                         round-robin pointer
// ---------------------------------------------------------------------------
package cdb_arbiter_pkg;

    localparam int NUM_FU    = 4;
    localparam int TAG_W     = 6;
    localparam int ROB_PTR_W = 5;
    localparam int DATA_W    = 32;

    localparam int FU_ALU = 0;
    localparam int FU_MDU = 1;
    localparam int FU_LSU = 2;
    localparam int FU_BR  = 3;

    typedef struct packed {
        logic [TAG_W-1:0]     tag;
        logic [DATA_W-1:0]    wdata;
        logic [ROB_PTR_W-1:0] inst_id;
    } cdb_pkt_t;

    // Successor of idx in a ring of n entries.
    function automatic int nextIdx(input int idx, input int n);
        return (idx >= n - 1) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/cdb_arbiter_if.sv
// ---------------------------------------------------------------------------
// cdb_arbiter_if
// Bundles the unit-to-CDB request/ready handshake and the CDB broadcast.
//   fu_req/fu_rdy           : per-unit valid / accept (transfer = req && rdy)
//   fu_tag/fu_wdata/fu_inst_id : per-unit result fields, held until transfer
//   cdb_vld/cdb_tag/cdb_wdata/cdb_inst_id/cdb_src : registered broadcast
// Modports:
//   slave  : the arbiter (consumes requests, drives ready and the broadcast)
//   master : the execution-unit / consumer side
// ---------------------------------------------------------------------------
interface cdb_arbiter_if #(
    parameter int NUM_FU    = cdb_arbiter_pkg::NUM_FU,
    parameter int TAG_W     = cdb_arbiter_pkg::TAG_W,
    parameter int ROB_PTR_W = cdb_arbiter_pkg::ROB_PTR_W,
    parameter int DATA_W    = cdb_arbiter_pkg::DATA_W
);

    logic [NUM_FU-1:0]                fu_req;
    logic [NUM_FU-1:0]                fu_rdy;
    logic [NUM_FU-1:0][TAG_W-1:0]     fu_tag;
    logic [NUM_FU-1:0][DATA_W-1:0]    fu_wdata;
    logic [NUM_FU-1:0][ROB_PTR_W-1:0] fu_inst_id;

    logic                             cdb_vld;
    logic [TAG_W-1:0]                 cdb_tag;
    logic [DATA_W-1:0]                cdb_wdata;
    logic [ROB_PTR_W-1:0]             cdb_inst_id;
    logic [NUM_FU-1:0]                cdb_src;

    modport slave (
        input  fu_req, fu_tag, fu_wdata, fu_inst_id,
        output fu_rdy,
        output cdb_vld, cdb_tag, cdb_wdata, cdb_inst_id, cdb_src
    );

    modport master (
        output fu_req, fu_tag, fu_wdata, fu_inst_id,
        input  fu_rdy,
        input  cdb_vld, cdb_tag, cdb_wdata, cdb_inst_id, cdb_src
    );

endinterface

// File: rtl/cdb_arbiter_rr_arbiter.sv
// ---------------------------------------------------------------------------
// rr_arbiter
// Purely combinational round-robin selector, reusable by any N-way select.
//   i_req    [N]     : request vector
//   i_ptr    [IDX_W] : highest-priority index this cycle
//   o_gnt    [N]     : one-hot grant, zero when no request
//   o_gntIdx [IDX_W] : encoded grant index (0 when no grant)
// The search starts at i_ptr and walks upward, wrapping from N-1 to 0.
// ---------------------------------------------------------------------------
module rr_arbiter #(
    parameter int N     = 4,
    parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]     i_req,
    input  logic [IDX_W-1:0] i_ptr,
    output logic [N-1:0]     o_gnt,
    output logic [IDX_W-1:0] o_gntIdx
);

    logic             w_found;
    logic [IDX_W-1:0] w_idx;

    // Visit candidates in priority order and keep the first one requesting.
    always_comb begin
        o_gnt    = '0;
        o_gntIdx = '0;
        w_found  = 1'b0;
        w_idx    = '0;
        for (int k = 0; k < N; k++) begin
            w_idx = IDX_W'((int'(i_ptr) + k) % N);
            if (!w_found && i_req[w_idx]) begin
                w_found        = 1'b1;
                o_gnt[w_idx]   = 1'b1;
                o_gntIdx       = w_idx;
            end
        end
    end

endmodule

// File: rtl/cdb_arbiter.sv
// ---------------------------------------------------------------------------
// cdb_arbiter
// Shares the single common data bus among the execution units (ALU, MUL/DIV,
// LSU, branch). One unit is granted per cycle by round robin and its result is
// registered onto the CDB broadcast one cycle later.
//   clk, rst  : clock, synchronous active-high reset
//   i_flush   : mispredict flush; no grant this cycle, so no broadcast next
//   bus       : cdb_arbiter_if.slave (unit handshake + CDB broadcast)
// The broadcast is never back-pressured; a grant always completes.
// ---------------------------------------------------------------------------
module cdb_arbiter #(
    parameter int NUM_FU    = 4,
    parameter int TAG_W     = 6,
    parameter int ROB_PTR_W = 5,
    parameter int DATA_W    = 32
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           i_flush,
    cdb_arbiter_if.slave   bus
);

    import cdb_arbiter_pkg::*;

    localparam int PTR_W = (NUM_FU > 1) ? $clog2(NUM_FU) : 1;

    logic [PTR_W-1:0]     r_rrPtr;
    logic [NUM_FU-1:0]    w_reqGated;
    logic [NUM_FU-1:0]    w_gnt;
    logic [PTR_W-1:0]     w_gntIdx;
    logic                 w_xfer;

    logic                 r_cdbVld;
    logic [NUM_FU-1:0]    r_cdbSrc;
    logic [TAG_W-1:0]     r_cdbTag;
    logic [DATA_W-1:0]    r_cdbWdata;
    logic [ROB_PTR_W-1:0] r_cdbInstId;

    // Masking requests (rather than the grant) keeps fu_rdy at zero during
    // reset and flush while the selector itself stays a pure function.
    assign w_reqGated = (rst || i_flush) ? '0 : bus.fu_req;

    rr_arbiter #(
        .N     (NUM_FU),
        .IDX_W (PTR_W)
    ) u_rrArbiter (
        .i_req    (w_reqGated),
        .i_ptr    (r_rrPtr),
        .o_gnt    (w_gnt),
        .o_gntIdx (w_gntIdx)
    );

    // A grant is only ever given to a requester, so any grant is a transfer.
    assign w_xfer     = |w_gnt;
    assign bus.fu_rdy = w_gnt;

    // Priority moves just past the last winner; it holds on idle and flush.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rrPtr <= '0;
        end else if (w_xfer) begin
            r_rrPtr <= PTR_W'(nextIdx(int'(w_gntIdx), NUM_FU));
        end
    end

    // Broadcast register: valid/source follow the transfer every cycle,
    // while the payload only loads on a transfer so it holds when idle.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cdbVld    <= 1'b0;
            r_cdbSrc    <= '0;
            r_cdbTag    <= '0;
            r_cdbWdata  <= '0;
            r_cdbInstId <= '0;
        end else begin
            r_cdbVld <= w_xfer;
            r_cdbSrc <= w_gnt;
            if (w_xfer) begin
                r_cdbTag    <= bus.fu_tag[w_gntIdx];
                r_cdbWdata  <= bus.fu_wdata[w_gntIdx];
                r_cdbInstId <= bus.fu_inst_id[w_gntIdx];
            end
        end
    end

    assign bus.cdb_vld     = r_cdbVld;
    assign bus.cdb_src     = r_cdbSrc;
    assign bus.cdb_tag     = r_cdbTag;
    assign bus.cdb_wdata   = r_cdbWdata;
    assign bus.cdb_inst_id = r_cdbInstId;

endmodule

// File: tb/tb_cdb_arbiter.sv
// ---------------------------------------------------------------------------
// tb_cdb_arbiter
// Directed vector table for the documented scenarios, an idle stretch, then
// randomized unit traffic compared against a behavioural reference model.
// ---------------------------------------------------------------------------
module tb_cdb_arbiter;

    import cdb_arbiter_pkg::*;

    logic clk = 1'b0;
    logic rst;
    logic flush;

    always #5 clk = ~clk;

    cdb_arbiter_if u_if ();

    cdb_arbiter dut (
        .clk     (clk),
        .rst     (rst),
        .i_flush (flush),
        .bus     (u_if)
    );

    int checks   = 0;
    int failures = 0;

    // Reference model state: expected broadcast and round-robin pointer.
    int        mPtr;
    logic      mVld;
    logic [3:0] mSrc;
    cdb_pkt_t  mPkt;

    // What each unit is presenting.
    cdb_pkt_t  unitPkt [NUM_FU];
    logic [3:0] unitPend;
    int        waitCnt [NUM_FU];

    typedef struct {
        string      name;
        logic       rst;
        logic       flush;
        logic [3:0] req;
        logic [3:0] expRdy;
        logic       expVld;
        logic [3:0] expSrc;
    } vec_t;

    vec_t tab [$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // First requester at or after the pointer, wrapping around the ring.
    function automatic logic [3:0] modelGrant();
        logic [3:0] g;
        g = '0;
        if (!rst && !flush) begin
            for (int k = 0; k < NUM_FU; k++) begin
                int i;
                i = (mPtr + k) % NUM_FU;
                if (g == 4'b0 && u_if.fu_req[i]) g[i] = 1'b1;
            end
        end
        return g;
    endfunction

    task automatic applyStimulus(input logic r, input logic f, input logic [3:0] req);
        rst   = r;
        flush = f;
        u_if.fu_req = req;
        for (int i = 0; i < NUM_FU; i++) begin
            u_if.fu_tag[i]     = unitPkt[i].tag;
            u_if.fu_wdata[i]   = unitPkt[i].wdata;
            u_if.fu_inst_id[i] = unitPkt[i].inst_id;
        end
    endtask

    task automatic checkOutput(input string name);
        check({name, ".fu_rdy"},      32'(u_if.fu_rdy),      32'(modelGrant()));
        check({name, ".cdb_vld"},     32'(u_if.cdb_vld),     32'(mVld));
        check({name, ".cdb_src"},     32'(u_if.cdb_src),     32'(mSrc));
        check({name, ".cdb_tag"},     32'(u_if.cdb_tag),     32'(mPkt.tag));
        check({name, ".cdb_wdata"},   32'(u_if.cdb_wdata),   32'(mPkt.wdata));
        check({name, ".cdb_inst_id"}, 32'(u_if.cdb_inst_id), 32'(mPkt.inst_id));
        check({name, ".rr_ptr"},      32'(dut.r_rrPtr),      32'(mPtr));
    endtask

    // Advance the model by the clock edge that ends the current cycle.
    task automatic modelUpdate(output logic [3:0] g);
        g = modelGrant();
        if (rst) begin
            mPtr = 0;
            mVld = 1'b0;
            mSrc = '0;
            mPkt = '0;
        end else if (g != 4'b0) begin
            for (int i = 0; i < NUM_FU; i++) begin
                if (g[i]) begin
                    mPkt = unitPkt[i];
                    mPtr = (i + 1) % NUM_FU;
                end
            end
            mVld = 1'b1;
            mSrc = g;
        end else begin
            mVld = 1'b0;
            mSrc = '0;
        end
    endtask

    task automatic runCycle(input string name, input logic useTab, input vec_t v,
                            output logic [3:0] g);
        @(negedge clk);
        checkOutput(name);
        if (useTab) begin
            check({name, ".tab_rdy"}, 32'(u_if.fu_rdy),  32'(v.expRdy));
            check({name, ".tab_vld"}, 32'(u_if.cdb_vld), 32'(v.expVld));
            check({name, ".tab_src"}, 32'(u_if.cdb_src), 32'(v.expSrc));
        end
        @(posedge clk);
        modelUpdate(g);
        #1;
    endtask

    function automatic cdb_pkt_t randPkt();
        cdb_pkt_t p;
        p.tag     = TAG_W'($urandom_range(0, 63));
        p.wdata   = $urandom;
        p.inst_id = ROB_PTR_W'($urandom_range(0, 31));
        return p;
    endfunction

    initial begin
        vec_t       v;
        logic [3:0] g;

        unitPkt[FU_ALU] = '{tag: 6'd5,  wdata: 32'h0000_1234, inst_id: 5'd3};
        unitPkt[FU_MDU] = '{tag: 6'd0,  wdata: 32'hAAAA_0001, inst_id: 5'd7};
        unitPkt[FU_LSU] = '{tag: 6'd22, wdata: 32'hDEAD_BEEF, inst_id: 5'd12};
        unitPkt[FU_BR]  = '{tag: 6'd63, wdata: 32'hFFFF_FFFF, inst_id: 5'd31};

        applyStimulus(1'b1, 1'b0, 4'b0000);
        repeat (2) @(posedge clk);
        #1;
        mPtr = 0;
        mVld = 1'b0;
        mSrc = '0;
        mPkt = '0;

        //               name       rst   flush req      rdy      vld   src
        tab.push_back('{"rst",      1'b1, 1'b0, 4'b1111, 4'b0000, 1'b0, 4'b0000});
        tab.push_back('{"single",   1'b0, 1'b0, 4'b0001, 4'b0001, 1'b0, 4'b0000});
        tab.push_back('{"singleB",  1'b0, 1'b0, 4'b0000, 4'b0000, 1'b1, 4'b0001});
        tab.push_back('{"rst2",     1'b1, 1'b0, 4'b0000, 4'b0000, 1'b0, 4'b0000});
        tab.push_back('{"all0",     1'b0, 1'b0, 4'b1111, 4'b0001, 1'b0, 4'b0000});
        tab.push_back('{"all1",     1'b0, 1'b0, 4'b1111, 4'b0010, 1'b1, 4'b0001});
        tab.push_back('{"all2",     1'b0, 1'b0, 4'b1111, 4'b0100, 1'b1, 4'b0010});
        tab.push_back('{"all3",     1'b0, 1'b0, 4'b1111, 4'b1000, 1'b1, 4'b0100});
        tab.push_back('{"all4",     1'b0, 1'b0, 4'b1111, 4'b0001, 1'b1, 4'b1000});
        tab.push_back('{"midRst",   1'b1, 1'b0, 4'b1111, 4'b0000, 1'b1, 4'b0001});
        tab.push_back('{"postRst",  1'b0, 1'b0, 4'b0110, 4'b0010, 1'b0, 4'b0000});
        tab.push_back('{"flush",    1'b0, 1'b1, 4'b0101, 4'b0000, 1'b1, 4'b0010});
        tab.push_back('{"postFl",   1'b0, 1'b0, 4'b0101, 4'b0100, 1'b0, 4'b0000});
        tab.push_back('{"wrap",     1'b0, 1'b0, 4'b1010, 4'b1000, 1'b1, 4'b0100});
        tab.push_back('{"wrapB",    1'b0, 1'b0, 4'b0010, 4'b0010, 1'b1, 4'b1000});
        tab.push_back('{"drain",    1'b0, 1'b0, 4'b0000, 4'b0000, 1'b1, 4'b0010});
        tab.push_back('{"ptr2",     1'b0, 1'b0, 4'b0001, 4'b0001, 1'b0, 4'b0000});
        tab.push_back('{"rstFl",    1'b1, 1'b1, 4'b1111, 4'b0000, 1'b1, 4'b0001});
        tab.push_back('{"afterRF",  1'b0, 1'b0, 4'b1000, 4'b1000, 1'b0, 4'b0000});

        for (int n = 0; n < tab.size(); n++) begin
            applyStimulus(tab[n].rst, tab[n].flush, tab[n].req);
            runCycle(tab[n].name, 1'b1, tab[n], g);
        end

        // Idle stretch: payload must hold the branch unit's last result.
        v = tab[0];
        for (int n = 0; n < 10; n++) begin
            applyStimulus(1'b0, 1'b0, 4'b0000);
            runCycle("idle", 1'b0, v, g);
        end
        check("idle.hold_wdata", 32'(u_if.cdb_wdata), 32'hFFFF_FFFF);

        // Randomized traffic; units hold each result until it transfers.
        unitPend = '0;
        for (int i = 0; i < NUM_FU; i++) waitCnt[i] = 0;
        for (int n = 0; n < 3000; n++) begin
            logic r;
            logic f;
            r = ($urandom_range(0, 99) == 0);
            f = ($urandom_range(0, 15) == 0);
            applyStimulus(r, f, unitPend);
            runCycle("rand", 1'b0, v, g);
            for (int i = 0; i < NUM_FU; i++) begin
                if (r || f || !unitPend[i]) begin
                    waitCnt[i] = 0;
                end else if (g[i]) begin
                    check("starve_bound", 32'(waitCnt[i] < NUM_FU), 32'd1);
                    waitCnt[i] = 0;
                end else begin
                    waitCnt[i]++;
                    if (waitCnt[i] == NUM_FU) begin
                        check("starve_timeout", 32'(waitCnt[i]), 32'(NUM_FU - 1));
                        waitCnt[i] = 0;
                    end
                end
                if (r) begin
                    unitPend[i] = 1'b0;
                end else if (g[i] || !unitPend[i]) begin
                    unitPend[i] = ($urandom_range(0, 3) != 0);
                    unitPkt[i]  = randPkt();
                end
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/cdb_arbiter.md
# cdb_arbiter

Round-robin arbiter that shares the single common data bus (CDB) among the execution units: ALU, MUL/DIV, LSU, and branch. Each unit presents a result on its unit-to-CDB request/ready handshake and holds it until it is accepted. The arbiter grants at most one unit per cycle and registers the winning result onto the CDB broadcast. The broadcast feeds the reservation stations, the register file and the ROB.

## Interface
Parameters:
- NUM_FU, 4: number of requesting units (≥2); index 0 = ALU, 1 = MUL/DIV, 2 = LSU, 3 = BR.
- TAG_W, 6: physical destination tag width.
- ROB_PTR_W, 5: ROB index width.
- DATA_W, 32: result width.

Ports:
- Reset is rst, synchronous, active-high. The clock is clk.
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- flush  in  1  pipeline flush (mispredict); kills the pending broadcast and suppresses grants for the cycle.
- fu_req  in  NUM_FU  per-unit result valid.
- fu_rdy  out  NUM_FU  per-unit accept; one-hot or zero.
- fu_tag  in  NUM_FU×TAG_W  per-unit destination tag.
- fu_wdata  in  NUM_FU×DATA_W  per-unit result data.
- fu_inst_id  in  NUM_FU×ROB_PTR_W  per-unit ROB index.
- cdb_vld  out  1  broadcast valid.
- cdb_tag  out  TAG_W  broadcast tag.
- cdb_wdata  out  DATA_W  broadcast data.
- cdb_inst_id  out  ROB_PTR_W  broadcast ROB index.
- cdb_src  out  NUM_FU  one-hot source of the current broadcast (debug/perf).

## Operation
- Handshake: a unit's result transfers in the cycle where fu_req[i] && fu_rdy[i].
  - A unit holds req/tag/wdata/inst_id stable until the transfer.
  - fu_req must not depend combinationally on fu_rdy.
- Grant: fu_rdy = one-hot round-robin choice among the asserted fu_req. The search starts at rr_ptr and goes upward, wrapping at NUM_FU−1 → 0.
- fu_rdy is all-zero when no unit requests, and all-zero when flush=1.
- Pointer: on a transfer from unit g, rr_ptr ← (g+1) mod NUM_FU. With no transfer, rr_ptr holds.
- Output register: on a transfer, the next cycle drives
  - cdb_vld = 1,
  - cdb_tag / cdb_wdata / cdb_inst_id = the winner's fields,
  - cdb_src = the grant vector.
- With no transfer, the next cycle drives cdb_vld = 0 and cdb_src = 0. The data fields hold their last values.
- The broadcast is never back-pressured: one result per cycle, sustained.
- Tags pass through unmodified, including tag 0. Suppressing writes to the zero register is the consumer's job.
- Flush: when flush=1 in cycle t,
  - no grant is made in t,
  - cdb_vld = 0 in t+1,
  - rr_ptr holds.
  - A broadcast already registered (visible in cycle t) is not retracted.
- Starvation bound: a continuously requesting unit is granted within NUM_FU cycles of first asserting req, provided flush stays low.

## Timing
- Grant latency: combinational. fu_rdy is valid in the same cycle as fu_req.
- Broadcast latency: 1 cycle after the transfer.
- Throughput: 1 result per cycle total.
- A unit with a one-entry output buffer that is continuously granted sustains back-to-back transfers. The next grant goes to it only when it is the sole requester, or when rr_ptr comes back around to it.
- Reset: rr_ptr = 0, cdb_vld = 0, cdb_src = 0, cdb_tag = 0, cdb_wdata = 0, cdb_inst_id = 0. fu_rdy is 0 while rst=1.
- Reset mid-operation: a registered broadcast is dropped (cdb_vld = 0 next cycle). Units are reset by the same rst.
- Simultaneous flush and rst: rst dominates; the result is the reset state.

## Structure
- rv32i_types gets:
  - typedef cdb_pkt_t {tag, wdata, inst_id},
  - localparam FU_ALU / FU_MDU / FU_LSU / FU_BR indices,
  - NUM_FU.
- Sub-module rr_arbiter #(N): purely combinational.
  - Inputs: req[N], ptr.
  - Outputs: one-hot gnt[N] and the encoded gnt_idx.
  - It is reused later by the RS issue-select logic.
- cdb_arbiter holds rr_ptr, the output register, and the flush gating.

## Test plan
- Single requester: ALU req, tag=5, wdata=0x1234, inst_id=3.
  - fu_rdy=0001 in the same cycle.
  - Next cycle: cdb_vld=1, tag=5, wdata=0x1234, inst_id=3, cdb_src=0001.
  - rr_ptr=1.
- All four request continuously from reset, each unit holding req:
  - grants go 0,1,2,3,0,… on consecutive cycles,
  - cdb_src is 0001,0010,0100,1000 with a one-cycle lag,
  - no idle cycle appears.
- Wrap: rr_ptr=3, requests on units 1 and 3 → unit 3 granted and rr_ptr=0. Next cycle, unit 1 is granted.
- Flush: units 0 and 2 request in cycle t with flush=1.
  - fu_rdy=0000 in t; cdb_vld=0 in t+1; rr_ptr unchanged.
  - With flush=0 in t+1, the grant follows the prior pointer.
- Reset mid-stream: assert rst while cdb_vld=1.
  - Next cycle: all outputs 0 and rr_ptr=0.
  - The first request after reset goes to the lowest requesting index.
- Idle: no requests for 10 cycles → cdb_vld=0, fu_rdy=0, rr_ptr stable, data fields hold their last values.
